// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter that multiplexes three burst requesters
// (colourspace converter, IDCT fetch, IDCT write-back) onto one SRAM port.
// The owner keeps the port until it drops its request or uses up MAX_BURST
// beats. A read-tag pipeline routes each returned word to the requester that
// issued it, even after ownership has moved on.
module sram_arbiter #(
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 64
) (
  input  logic             Clock_50,
  input  logic             Reset,
  input  logic [2:0]       M_req,
  input  logic [2:0]       M_we_n,
  input  logic [2:0][17:0] M_address,
  input  logic [2:0][15:0] M_write_data,
  output logic [2:0]       M_grant,
  output logic [2:0]       M_read_valid,
  output logic [15:0]      M_read_data,
  output logic [17:0]      SRAM_address,
  output logic [15:0]      SRAM_write_data,
  output logic             SRAM_we_n,
  input  logic [15:0]      SRAM_read_data
);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  localparam logic [6:0] MAX_BEATS = 7'(MAX_BURST);
  localparam logic [6:0] LAST_BEAT = 7'(MAX_BURST - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_owner;
  logic [1:0]  r_lastOwner;
  logic [2:0]  r_grant;
  logic [6:0]  r_beatCount;
  logic [17:0] r_sramAddress;
  logic [15:0] r_sramWriteData;
  logic        r_sramWeN;
  logic [READ_LATENCY:0][2:0] r_tagPipe;

  logic [1:0]  w_rrStart;
  logic [1:0]  w_winner;
  logic        w_anyReq;
  logic        w_accept;
  logic        w_lastBeat;
  logic        w_release;
  logic        w_doGrant;
  logic        w_doIdle;
  logic [2:0]  w_grantNext;
  logic [2:0]  w_tagIn;

  // Advances a requester index modulo 3.
  function automatic logic [1:0] nextIdx(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign w_anyReq   = |M_req;
  assign w_accept   = |(r_grant & M_req);
  assign w_lastBeat = w_accept && (r_beatCount == LAST_BEAT);
  assign w_release  = (r_state == S_BUSY) && (!M_req[r_owner] || w_lastBeat);
  assign w_tagIn    = (w_accept && M_we_n[r_owner]) ? (3'b001 << r_owner) : 3'b000;

  // Round-robin pick: search starts one past the current owner when busy,
  // one past the last released owner when idle; nearest requester wins.
  always_comb begin
    w_rrStart = (r_state == S_BUSY) ? nextIdx(r_owner) : nextIdx(r_lastOwner);
    w_winner  = w_rrStart;
    if (M_req[nextIdx(nextIdx(w_rrStart))]) w_winner = nextIdx(nextIdx(w_rrStart));
    if (M_req[nextIdx(w_rrStart)])          w_winner = nextIdx(w_rrStart);
    if (M_req[w_rrStart])                   w_winner = w_rrStart;
  end

  // FSM state register.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_stateNext;
  end

  // FSM next state: grant from idle, and re-grant or go idle on release.
  always_comb begin
    w_stateNext = r_state;
    w_doGrant   = 1'b0;
    w_doIdle    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_anyReq) begin
          w_stateNext = S_BUSY;
          w_doGrant   = 1'b1;
        end
      end
      S_BUSY: begin
        if (w_release) begin
          if (w_anyReq) begin
            w_doGrant = 1'b1;
          end else begin
            w_stateNext = S_IDLE;
            w_doIdle    = 1'b1;
          end
        end
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  // FSM outputs: next one-hot grant vector.
  always_comb begin
    w_grantNext = r_grant;
    if (w_doGrant)     w_grantNext = 3'b001 << w_winner;
    else if (w_doIdle) w_grantNext = 3'b000;
  end

  // Ownership bookkeeping: grant, owner index, last owner and beat counter.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_grant     <= 3'b000;
      r_owner     <= 2'd0;
      r_lastOwner <= 2'd2;
      r_beatCount <= 7'd0;
    end else begin
      r_grant <= w_grantNext;
      if (w_doGrant) r_owner <= w_winner;
      if (w_release) r_lastOwner <= r_owner;
      if (w_doGrant)
        r_beatCount <= 7'd0;
      else if (w_accept && (r_beatCount != MAX_BEATS))
        r_beatCount <= r_beatCount + 7'd1;
    end
  end

  // SRAM command register: load the owner's beat, otherwise park as a read.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_sramAddress   <= 18'd0;
      r_sramWriteData <= 16'd0;
      r_sramWeN       <= 1'b1;
    end else if (w_accept) begin
      r_sramAddress   <= M_address[r_owner];
      r_sramWriteData <= M_write_data[r_owner];
      r_sramWeN       <= M_we_n[r_owner];
    end else begin
      r_sramWeN <= 1'b1;
    end
  end

  // Read-tag pipeline: a one-hot requester tag per accepted read, emerging
  // from the last stage exactly when the SRAM returns that word.
  always_ff @(posedge Clock_50 or posedge Reset) begin
    if (Reset) begin
      r_tagPipe <= '0;
    end else begin
      for (int k = READ_LATENCY; k > 0; k--) r_tagPipe[k] <= r_tagPipe[k-1];
      r_tagPipe[0] <= w_tagIn;
    end
  end

  assign M_grant         = r_grant;
  assign M_read_valid    = r_tagPipe[READ_LATENCY];
  assign M_read_data     = SRAM_read_data;
  assign SRAM_address    = r_sramAddress;
  assign SRAM_write_data = r_sramWriteData;
  assign SRAM_we_n       = r_sramWeN;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed tests for sram_arbiter with a transaction-level
// reference model compared against the outputs every cycle.
module tb_sram_arbiter;

  localparam int READ_LATENCY = 2;
  localparam int MAX_BURST    = 64;

  logic             clock;
  logic             Reset;
  logic [2:0]       M_req;
  logic [2:0]       M_we_n;
  logic [2:0][17:0] M_address;
  logic [2:0][15:0] M_write_data;
  logic [2:0]       M_grant;
  logic [2:0]       M_read_valid;
  logic [15:0]      M_read_data;
  logic [17:0]      SRAM_address;
  logic [15:0]      SRAM_write_data;
  logic             SRAM_we_n;
  logic [15:0]      SRAM_read_data;

  sram_arbiter #(.READ_LATENCY(READ_LATENCY), .MAX_BURST(MAX_BURST)) dut (
    .Clock_50(clock), .Reset(Reset), .M_req(M_req), .M_we_n(M_we_n),
    .M_address(M_address), .M_write_data(M_write_data), .M_grant(M_grant),
    .M_read_valid(M_read_valid), .M_read_data(M_read_data),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data),
    .SRAM_we_n(SRAM_we_n), .SRAM_read_data(SRAM_read_data)
  );

  int total = 0;
  int bad   = 0;
  bit started = 0;

  // requester agents: beats still to issue, next address/data, read or write
  int          drvRem [3];
  logic [17:0] drvAddr[3];
  logic [15:0] drvData[3];
  logic        drvWe  [3];

  // reference model state
  int          n = 0;
  int          mOwner = -1;
  int          mLast = 2;
  int          mBeats = 0;
  int          mAcceptId = -1;
  logic [17:0] mAddr = '0;
  logic [15:0] mData = '0;
  logic        mWe = 1'b1;
  int          dueQ[$];
  int          idQ[$];

  int rvCount[3];

  // grant run tracker
  logic [2:0] runVal[16];
  int         runLen[16];
  int         runCount;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  function automatic int pick(input int start, input logic [2:0] req);
    for (int k = 0; k < 3; k++) begin
      int c;
      c = (start + k) % 3;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  // Reference model: one transaction step per clock edge, cleared by reset.
  always @(posedge clock or posedge Reset) begin
    if (Reset) begin
      mOwner = -1; mLast = 2; mBeats = 0; mAcceptId = -1;
      mAddr = '0; mData = '0; mWe = 1'b1;
      dueQ.delete(); idQ.delete();
    end else begin
      n++;
      mAcceptId = -1;
      if (mOwner >= 0 && M_req[mOwner]) begin
        mAcceptId = mOwner;
        mAddr = M_address[mOwner];
        mData = M_write_data[mOwner];
        mWe   = M_we_n[mOwner];
        if (M_we_n[mOwner]) begin
          dueQ.push_back(n + READ_LATENCY);
          idQ.push_back(mOwner);
        end
        mBeats++;
      end else begin
        mWe = 1'b1;
      end
      if (mOwner >= 0) begin
        if (!M_req[mOwner] || mBeats == MAX_BURST) begin
          mLast  = mOwner;
          mOwner = pick(mOwner + 1, M_req);
          mBeats = 0;
        end
      end else if (|M_req) begin
        mOwner = pick(mLast + 1, M_req);
        mBeats = 0;
      end
    end
  end

  // Compare process: every output against the model, mid-cycle.
  always @(negedge clock) begin
    logic [2:0] expRv;
    logic [2:0] expGrant;
    expRv = 3'b000;
    foreach (dueQ[k]) if (dueQ[k] == n) expRv |= 3'(1 << idQ[k]);
    while (dueQ.size() > 0 && dueQ[0] <= n) begin
      void'(dueQ.pop_front());
      void'(idQ.pop_front());
    end
    expGrant = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
    for (int i = 0; i < 3; i++) if (M_read_valid[i]) rvCount[i]++;
    if (started) begin
      checkOutput("grant", 32'(M_grant), 32'(expGrant));
      checkOutput("readValid", 32'(M_read_valid), 32'(expRv));
      checkOutput("sramWeN", 32'(SRAM_we_n), 32'(mWe));
      checkOutput("sramAddr", 32'(SRAM_address), 32'(mAddr));
      checkOutput("sramData", 32'(SRAM_write_data), 32'(mData));
      checkOutput("readData", 32'(M_read_data), 32'(SRAM_read_data));
    end
  end

  task automatic driveNow();
    for (int i = 0; i < 3; i++) begin
      M_req[i]        = (drvRem[i] > 0);
      M_we_n[i]       = drvWe[i];
      M_address[i]    = drvAddr[i];
      M_write_data[i] = drvData[i];
    end
  endtask

  task automatic clearDrivers();
    for (int i = 0; i < 3; i++) begin
      drvRem[i] = 0; drvAddr[i] = '0; drvData[i] = '0; drvWe[i] = 1'b1;
    end
    driveNow();
  endtask

  // One clock: advance the agent whose beat was taken, then drive inputs.
  task automatic applyStimulus();
    @(posedge clock);
    #1;
    if (mAcceptId >= 0 && !Reset) begin
      drvRem[mAcceptId]--;
      drvAddr[mAcceptId] = drvAddr[mAcceptId] + 18'd1;
      drvData[mAcceptId] = drvData[mAcceptId] + 16'd1;
    end
    SRAM_read_data = 16'($urandom);
    driveNow();
  endtask

  task automatic trackReset();
    runCount = 0;
  endtask

  task automatic trackGrant();
    if (runCount == 0) begin
      if (M_grant != 3'b000) begin
        runVal[0] = M_grant; runLen[0] = 1; runCount = 1;
      end
    end else if (M_grant == runVal[runCount-1]) begin
      runLen[runCount-1]++;
    end else if (runCount < 16) begin
      runVal[runCount] = M_grant; runLen[runCount] = 1; runCount++;
    end
  endtask

  task automatic doReset();
    Reset = 1'b1;
    clearDrivers();
    #1;
    for (int i = 0; i < 3; i++) rvCount[i] = 0;
    checkOutput("rstGrant", 32'(M_grant), 32'd0);
    checkOutput("rstReadValid", 32'(M_read_valid), 32'd0);
    checkOutput("rstWeN", 32'(SRAM_we_n), 32'd1);
    checkOutput("rstAddr", 32'(SRAM_address), 32'd0);
    checkOutput("rstData", 32'(SRAM_write_data), 32'd0);
    applyStimulus();
    applyStimulus();
    Reset = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    SRAM_read_data = 16'h0000;
    clearDrivers();
    repeat (2) @(posedge clock);
    #1;
    started = 1;

    // single requester, four reads at addresses 0..3
    doReset();
    drvRem[0] = 4; drvAddr[0] = 18'd0; drvWe[0] = 1'b1;
    driveNow();
    applyStimulus();
    checkOutput("firstGrant", 32'(M_grant), 32'h1);
    for (int s = 2; s <= 5; s++) begin
      applyStimulus();
      checkOutput("addrSeq", 32'(SRAM_address), 32'(s - 2));
    end
    repeat (6) applyStimulus();
    checkOutput("burstReadPulses", 32'(rvCount[0]), 32'd4);

    // all three requesting continuously: 64-beat rotation without gaps
    doReset();
    drvRem[0] = 1000; drvAddr[0] = 18'd1000; drvWe[0] = 1'b1;
    drvRem[1] = 1000; drvAddr[1] = 18'd2000; drvWe[1] = 1'b1;
    drvRem[2] = 1000; drvAddr[2] = 18'd3000; drvWe[2] = 1'b0; drvData[2] = 16'h1200;
    driveNow();
    trackReset();
    repeat (1 + 3 * MAX_BURST + 5) begin
      applyStimulus();
      trackGrant();
    end
    checkOutput("rotRun0", 32'(runVal[0]), 32'h1);
    checkOutput("rotRun1", 32'(runVal[1]), 32'h2);
    checkOutput("rotRun2", 32'(runVal[2]), 32'h4);
    checkOutput("rotRun3", 32'(runVal[3]), 32'h1);
    checkOutput("rotLen0", 32'(runLen[0]), 32'd64);
    checkOutput("rotLen1", 32'(runLen[1]), 32'd64);
    checkOutput("rotLen2", 32'(runLen[2]), 32'd64);
    for (int i = 0; i < 3; i++) drvRem[i] = 0;
    driveNow();
    repeat (6) applyStimulus();

    // owner 1 drops after 5 beats while requester 2 waits
    doReset();
    drvRem[1] = 5; drvAddr[1] = 18'd500; drvWe[1] = 1'b1;
    drvRem[2] = 3; drvAddr[2] = 18'd900; drvWe[2] = 1'b0; drvData[2] = 16'h7700;
    driveNow();
    repeat (6) applyStimulus();
    checkOutput("dropStillOwner1", 32'(M_grant), 32'h2);
    applyStimulus();
    checkOutput("handoverTo2", 32'(M_grant), 32'h4);
    repeat (8) applyStimulus();

    // read by 0, then write-back by 2 of 16'hABCD to 76800
    doReset();
    drvRem[0] = 1; drvAddr[0] = 18'd100; drvWe[0] = 1'b1;
    drvRem[2] = 1; drvAddr[2] = 18'd76800; drvWe[2] = 1'b0; drvData[2] = 16'hABCD;
    driveNow();
    repeat (4) applyStimulus();
    checkOutput("wbWeN", 32'(SRAM_we_n), 32'd0);
    checkOutput("wbAddr", 32'(SRAM_address), 32'd76800);
    checkOutput("wbData", 32'(SRAM_write_data), 32'hABCD);
    repeat (6) applyStimulus();
    checkOutput("wbReadPulse0", 32'(rvCount[0]), 32'd1);
    checkOutput("wbReadPulse2", 32'(rvCount[2]), 32'd0);

    // reset mid-burst with two reads in flight
    doReset();
    drvRem[0] = 10; drvAddr[0] = 18'd40; drvWe[0] = 1'b1;
    driveNow();
    repeat (3) applyStimulus();
    doReset();
    repeat (10) applyStimulus();
    checkOutput("postRstPulse0", 32'(rvCount[0]), 32'd0);
    checkOutput("postRstPulse1", 32'(rvCount[1]), 32'd0);
    checkOutput("postRstPulse2", 32'(rvCount[2]), 32'd0);

    // lone requester 2 with 130 beats: 64+64+2 under one continuous grant
    doReset();
    drvRem[2] = 130; drvAddr[2] = 18'd5000; drvWe[2] = 1'b1;
    driveNow();
    trackReset();
    repeat (140) begin
      applyStimulus();
      trackGrant();
    end
    checkOutput("longRunVal", 32'(runVal[0]), 32'h4);
    checkOutput("longRunLen", 32'(runLen[0]), 32'd131);
    checkOutput("longRunEnd", 32'(runVal[1]), 32'h0);
    checkOutput("longReadPulses", 32'(rvCount[2]), 32'd130);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
